// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the table-driven I2C register sequencer.
// A table entry is 18 bits wide: {op[1:0], arg[15:0]}.
package i2c_seq_pkg;

    localparam int ENTRY_W = 18;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_END   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] arg;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_GO        = 3'd2,
        S_WAIT_ACKD = 3'd3,
        S_WAIT_END  = 3'd4,
        S_DELAY     = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    // Index/bookkeeping action chosen by the FSM in a given cycle
    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_RESTART = 2'd1,
        ACT_ADVANCE = 2'd2
    } act_e;

endpackage

// File: rtl/i2c_seq_timer.sv
// Two-level delay counter: a tick counter loaded with the entry argument and
// a unit counter that divides iCLK down to one tick every DELAY_UNIT cycles.
// After a load of arg (non-zero), done pulses on the arg*DELAY_UNIT-th cycle.
module i2c_seq_timer #(
    parameter int DELAY_UNIT = 50000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        load,
    input  logic [15:0] arg,
    input  logic        abort,
    output logic        busy,
    output logic        done
);

    localparam int UW = $clog2(DELAY_UNIT + 1);
    localparam logic [UW-1:0] UNIT_RELOAD = UW'(DELAY_UNIT);
    localparam logic [UW-1:0] UNIT_ONE    = UW'(1);

    logic [15:0]   tick_r;
    logic [UW-1:0] unit_r;

    assign busy = (tick_r != 16'd0);
    assign done = busy && (tick_r == 16'd1) && (unit_r == UNIT_ONE);

    // Count units down, stepping the tick counter each time a unit expires
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tick_r <= 16'd0;
            unit_r <= '0;
        end else if (abort || done) begin
            tick_r <= 16'd0;
            unit_r <= '0;
        end else if (load) begin
            tick_r <= arg;
            unit_r <= UNIT_RELOAD;
        end else if (busy) begin
            if (unit_r == UNIT_ONE) begin
                tick_r <= tick_r - 16'd1;
                unit_r <= UNIT_RELOAD;
            end else begin
                unit_r <= unit_r - UNIT_ONE;
            end
        end else begin
            tick_r <= tick_r;
            unit_r <= unit_r;
        end
    end

endmodule

// File: rtl/i2c_seq_config.sv
// Table-driven I2C register sequencer. Walks iTABLE from entry 0, issuing
// register writes through the I2C_Controller START/END/ACK handshake,
// inserting timed delays, and stopping at an END (or reserved) opcode or
// after the last table entry.
// Build option: define I2C_SEQ_RETRY_EN to bound NACK retries to MAX_RETRY
// per entry (then skip and flag oERR); otherwise a NACKed write is reissued
// until it is acknowledged and oERR stays 0.
module i2c_seq_config
    import i2c_seq_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter logic [7:0]  DEV_ADDR   = 8'h72,
    parameter int          DELAY_UNIT = 50000,
    parameter int          MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic [DEPTH*ENTRY_W-1:0]   iTABLE,
    input  logic                       iRESTART,
    output logic [23:0]                oI2C_DATA,
    output logic                       oI2C_GO,
    input  logic                       iI2C_END,
    input  logic                       iI2C_ACK,
    output logic [$clog2(DEPTH)-1:0]   oINDEX,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic                       oERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0]    RETRY_ONE = RW'(1);

    state_e            state_r, state_nxt;
    logic [IDX_W-1:0]  index_r, index_nxt;
    logic [RW-1:0]     retry_r, retry_nxt;
    logic              go_r, go_nxt;
    logic              busy_r, busy_nxt;
    logic              done_r, done_nxt;
    logic              err_r, err_nxt;
    logic              pend_r, pend_nxt;
    logic              auto_r, auto_nxt;

    entry_t            entry_s;
    act_e              act_s;
    logic              restart_req_s;
    logic              tmr_load_s;
    logic              tmr_abort_s;
    logic              tmr_busy_s;
    logic              tmr_done_s;

    assign entry_s       = iTABLE[int'(index_r)*ENTRY_W +: ENTRY_W];
    assign restart_req_s = iRESTART | pend_r;

    assign oI2C_DATA = {DEV_ADDR, entry_s.arg};
    assign oI2C_GO   = go_r;
    assign oINDEX    = index_r;
    assign oBUSY     = busy_r;
    assign oDONE     = done_r;
    assign oERR      = err_r;

    i2c_seq_timer #(
        .DELAY_UNIT (DELAY_UNIT)
    ) u_timer (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .load   (tmr_load_s),
        .arg    (entry_s.arg),
        .abort  (tmr_abort_s),
        .busy   (tmr_busy_s),
        .done   (tmr_done_s)
    );

    // Next-state, index/retry bookkeeping and registered-output decode
    always_comb begin
        state_nxt   = state_r;
        index_nxt   = index_r;
        retry_nxt   = retry_r;
        busy_nxt    = busy_r;
        done_nxt    = done_r;
        err_nxt     = err_r;
        pend_nxt    = pend_r | iRESTART;
        auto_nxt    = auto_r;
        tmr_load_s  = 1'b0;
        tmr_abort_s = 1'b0;
        act_s       = ACT_NONE;
        go_nxt      = 1'b0;

        case (state_r)
            S_IDLE: begin
                pend_nxt = 1'b0;
                if (auto_r || iRESTART) begin
                    auto_nxt = 1'b0;
                    act_s    = ACT_RESTART;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (restart_req_s) begin
                    act_s = ACT_RESTART;
                end else begin
                    case (entry_s.op)
                        OP_WRITE: state_nxt = S_GO;
                        OP_DELAY: begin
                            // A zero-length delay just moves to the next entry
                            if (entry_s.arg != 16'd0) begin
                                tmr_load_s = 1'b1;
                                state_nxt  = S_DELAY;
                            end else begin
                                act_s = ACT_ADVANCE;
                            end
                        end
                        default:  state_nxt = S_DONE;
                    endcase
                end
            end
            S_GO: begin
                state_nxt = S_WAIT_ACKD;
            end
            S_WAIT_ACKD: begin
                if (!iI2C_END) begin
                    state_nxt = S_WAIT_END;
                end else begin
                    state_nxt = S_WAIT_ACKD;
                end
            end
            S_WAIT_END: begin
                if (iI2C_END) begin
                    // The transaction is complete; a pending restart now wins
                    if (restart_req_s) begin
                        act_s = ACT_RESTART;
                    end else if (!iI2C_ACK) begin
                        act_s = ACT_ADVANCE;
`ifdef I2C_SEQ_RETRY_EN
                    end else if (retry_r == RETRY_MAX) begin
                        err_nxt = 1'b1;
                        act_s   = ACT_ADVANCE;
`endif
                    end else begin
                        // Consecutive NACK count on this entry, saturating
                        if (retry_r != RETRY_MAX) begin
                            retry_nxt = retry_r + RETRY_ONE;
                        end else begin
                            retry_nxt = retry_r;
                        end
                        state_nxt = S_GO;
                    end
                end else begin
                    state_nxt = S_WAIT_END;
                end
            end
            S_DELAY: begin
                if (restart_req_s) begin
                    tmr_abort_s = 1'b1;
                    act_s       = ACT_RESTART;
                end else if (tmr_done_s || !tmr_busy_s) begin
                    act_s = ACT_ADVANCE;
                end else begin
                    state_nxt = S_DELAY;
                end
            end
            S_DONE: begin
                if (restart_req_s) begin
                    act_s = ACT_RESTART;
                end else begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (act_s)
            ACT_RESTART: begin
                state_nxt = S_FETCH;
                index_nxt = '0;
                retry_nxt = '0;
                busy_nxt  = 1'b1;
                done_nxt  = 1'b0;
                err_nxt   = 1'b0;
                pend_nxt  = 1'b0;
            end
            ACT_ADVANCE: begin
                retry_nxt = '0;
                // Running off the end of the table behaves like END
                if (index_r == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    index_nxt = index_r + IDX_ONE;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                index_nxt = index_nxt;
            end
        endcase

        // START is held from the GO state until the controller drops END
        go_nxt = (state_nxt == S_GO) || (state_nxt == S_WAIT_ACKD);
    end

    // State and registered-output flops
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r <= S_IDLE;
            index_r <= '0;
            retry_r <= '0;
            go_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            pend_r  <= 1'b0;
            auto_r  <= AUTO_START;
        end else begin
            state_r <= state_nxt;
            index_r <= index_nxt;
            retry_r <= retry_nxt;
            go_r    <= go_nxt;
            busy_r  <= busy_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            pend_r  <= pend_nxt;
            auto_r  <= auto_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_seq_config.sv
// Directed self-checking bench for i2c_seq_config (DEPTH=4, DELAY_UNIT=10,
// MAX_RETRY=3, AUTO_START=1). A small I2C_Controller model answers each GO:
// END drops, stays low a few cycles, then returns high with ACK/NACK.
module tb_i2c_seq_config;

    localparam int DEPTH = 4;

    logic                clk;
    logic                rst_n;
    logic [DEPTH*18-1:0] table_bus;
    logic                restart;
    logic [23:0]         o_data;
    logic                o_go;
    logic                i2c_end;
    logic                i2c_ack;
    logic [1:0]          o_index;
    logic                o_busy;
    logic                o_done;
    logic                o_err;

    int                  checks;
    int                  passes;

    // controller model state
    int                  txn_cnt;
    logic [23:0]         txn_log [0:15];
    int                  nack_budget;
    logic                go_prev;
    logic                ctl_busy;
    logic                ctl_nack;
    int                  ctl_cnt;

    i2c_seq_config #(
        .DEPTH      (DEPTH),
        .DEV_ADDR   (8'h72),
        .DELAY_UNIT (10),
        .MAX_RETRY  (3),
        .AUTO_START (1'b1)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iTABLE    (table_bus),
        .iRESTART  (restart),
        .oI2C_DATA (o_data),
        .oI2C_GO   (o_go),
        .iI2C_END  (i2c_end),
        .iI2C_ACK  (i2c_ack),
        .oINDEX    (o_index),
        .oBUSY     (o_busy),
        .oDONE     (o_done),
        .oERR      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C controller model: the first nack_budget transactions are NACKed
    initial begin
        i2c_end  = 1'b1;
        i2c_ack  = 1'b0;
        go_prev  = 1'b0;
        ctl_busy = 1'b0;
        ctl_nack = 1'b0;
        ctl_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                i2c_end  = 1'b1;
                i2c_ack  = 1'b0;
                ctl_busy = 1'b0;
                go_prev  = 1'b0;
            end else begin
                if (ctl_busy) begin
                    if (ctl_cnt == 0) begin
                        i2c_ack  = ctl_nack;
                        i2c_end  = 1'b1;
                        ctl_busy = 1'b0;
                    end else begin
                        ctl_cnt = ctl_cnt - 1;
                    end
                end else if (o_go && !go_prev) begin
                    if (txn_cnt < 16) txn_log[txn_cnt] = o_data;
                    txn_cnt  = txn_cnt + 1;
                    ctl_nack = (nack_budget > 0);
                    if (nack_budget > 0) nack_budget = nack_budget - 1;
                    i2c_end  = 1'b0;
                    ctl_cnt  = 3;
                    ctl_busy = 1'b1;
                end
                go_prev = o_go;
            end
        end
    end

    function automatic logic [17:0] ent(input logic [1:0] op, input logic [15:0] arg);
        return {op, arg};
    endfunction

    // Load a table, pulse reset and release; AUTO_START begins the run
    task automatic start_run(input logic [17:0] e0, input logic [17:0] e1,
                             input logic [17:0] e2, input logic [17:0] e3,
                             input int nacks);
        @(negedge clk);
        rst_n       = 1'b0;
        restart     = 1'b0;
        table_bus   = {e3, e2, e1, e0};
        nack_budget = nacks;
        txn_cnt     = 0;
        for (int i = 0; i < 16; i++) txn_log[i] = 24'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n     = 1'b0;
        restart   = 1'b0;
        table_bus = {ent(2'b10, 16'h0), ent(2'b10, 16'h0), ent(2'b10, 16'h0), ent(2'b00, 16'h4110)};
        txn_cnt   = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_go, o_busy, o_done, o_err} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {o_go, o_busy, o_done, o_err});
        else passes++;
        checks++;
        if (o_index !== 2'd0) $display("FAIL reset_index: got %0d expected 0", o_index);
        else passes++;
        checks++;
        if (o_data !== 24'h724110) $display("FAIL reset_data: got %h expected 724110", o_data);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) $display("FAIL auto_start_busy: got %b expected 1", o_busy);
        else passes++;
    endtask

    task automatic test_write_seq;
        bit ok;
        start_run(ent(2'b00, 16'h4110), ent(2'b00, 16'h9803), ent(2'b10, 16'h0), ent(2'b10, 16'h0), 0);
        wait_done(200, ok);
        checks++;
        if (!ok) $display("FAIL write_done_timeout: got done=%b expected 1", o_done);
        else passes++;
        checks++;
        if (txn_cnt !== 2) $display("FAIL write_txn_count: got %0d expected 2", txn_cnt);
        else passes++;
        checks++;
        if (txn_log[0] !== 24'h724110 || txn_log[1] !== 24'h729803)
            $display("FAIL write_data: got %h,%h expected 724110,729803", txn_log[0], txn_log[1]);
        else passes++;
        checks++;
        if ({o_busy, o_done, o_err, o_index} !== 5'b01010)
            $display("FAIL write_final: got busy=%b done=%b err=%b idx=%0d expected 0,1,0,2", o_busy, o_done, o_err, o_index);
        else passes++;
    endtask

    // FETCH(entry0) at t, 30 delay cycles, FETCH(entry1) at t+31, GO at t+32
    task automatic measure_delay(input logic [15:0] arg, input int expect_cycles, input logic [15:0] wdata);
        int t;
        bit ok;
        start_run(ent(2'b01, arg), ent(2'b00, wdata), ent(2'b10, 16'h0), ent(2'b10, 16'h0), 0);
        for (int i = 0; i < 10 && !o_busy; i++) @(negedge clk);
        t = 0;
        for (int i = 0; i < 200 && !o_go; i++) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t !== expect_cycles) $display("FAIL delay_%0d_latency: got %0d cycles expected %0d", arg, t, expect_cycles);
        else passes++;
        wait_done(200, ok);
        checks++;
        if (!ok || txn_log[0] !== {8'h72, wdata}) $display("FAIL delay_%0d_data: got done=%b data=%h expected 1,72%h", arg, ok, txn_log[0], wdata);
        else passes++;
    endtask

    task automatic test_delay;
        measure_delay(16'd3, 32, 16'h1234);
        measure_delay(16'd0, 2, 16'h5555);
    endtask

    task automatic test_nack;
        bit ok;
`ifdef I2C_SEQ_RETRY_EN
        start_run(ent(2'b00, 16'h1111), ent(2'b00, 16'h2222), ent(2'b10, 16'h0), ent(2'b10, 16'h0), 4);
        wait_done(500, ok);
        checks++;
        if (!ok || txn_cnt !== 5) $display("FAIL retry_count: got done=%b txns=%0d expected 1,5", ok, txn_cnt);
        else passes++;
        checks++;
        if (txn_log[3] !== 24'h721111 || txn_log[4] !== 24'h722222)
            $display("FAIL retry_skip: got %h,%h expected 721111,722222", txn_log[3], txn_log[4]);
        else passes++;
        checks++;
        if (o_err !== 1'b1 || o_index !== 2'd2) $display("FAIL retry_err: got err=%b idx=%0d expected 1,2", o_err, o_index);
        else passes++;
`else
        start_run(ent(2'b00, 16'h1111), ent(2'b10, 16'h0), ent(2'b10, 16'h0), ent(2'b10, 16'h0), 5);
        wait_done(500, ok);
        checks++;
        if (!ok || txn_cnt !== 6) $display("FAIL nack_count: got done=%b txns=%0d expected 1,6", ok, txn_cnt);
        else passes++;
        checks++;
        if (txn_log[0] !== 24'h721111 || txn_log[5] !== 24'h721111)
            $display("FAIL nack_reissue: got %h,%h expected 721111,721111", txn_log[0], txn_log[5]);
        else passes++;
        checks++;
        if (o_err !== 1'b0 || o_index !== 2'd1) $display("FAIL nack_err: got err=%b idx=%0d expected 0,1", o_err, o_index);
        else passes++;
`endif
    endtask

    task automatic test_restart;
        bit early;
        bit ok;
        start_run(ent(2'b00, 16'h0101), ent(2'b00, 16'h0202), ent(2'b00, 16'h0303), ent(2'b10, 16'h0), 0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txn_cnt == 3 && ctl_busy && !o_go) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL restart_reach_entry2: got txns=%0d expected 3", txn_cnt);
        else passes++;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        early = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (o_done && txn_cnt < 6) early = 1'b1;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || early) $display("FAIL restart_done: got done=%b early=%b expected 1,0", ok, early);
        else passes++;
        checks++;
        if (txn_cnt !== 6 || txn_log[2] !== 24'h720303 || txn_log[3] !== 24'h720101 || txn_log[5] !== 24'h720303)
            $display("FAIL restart_order: got n=%0d %h %h %h expected 6 720303 720101 720303", txn_cnt, txn_log[2], txn_log[3], txn_log[5]);
        else passes++;
    endtask

    task automatic test_reset_mid_delay;
        bit ok;
        start_run(ent(2'b00, 16'h4110), ent(2'b01, 16'd3), ent(2'b00, 16'h1234), ent(2'b10, 16'h0), 0);
        for (int i = 0; i < 100 && !(o_index == 2'd1 && o_busy); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (o_index !== 2'd1 || o_busy !== 1'b1) $display("FAIL mid_delay_state: got idx=%0d busy=%b expected 1,1", o_index, o_busy);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_go, o_busy, o_done, o_err, o_index} !== 6'b000000)
            $display("FAIL async_reset: got go=%b busy=%b done=%b err=%b idx=%0d expected all 0", o_go, o_busy, o_done, o_err, o_index);
        else passes++;
        @(negedge clk);
        txn_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(300, ok);
        checks++;
        if (!ok || txn_cnt !== 2 || txn_log[0] !== 24'h724110 || txn_log[1] !== 24'h721234)
            $display("FAIL reset_rerun: got done=%b n=%0d %h %h expected 1 2 724110 721234", ok, txn_cnt, txn_log[0], txn_log[1]);
        else passes++;
    endtask

    task automatic test_table_end;
        bit ok;
        start_run(ent(2'b00, 16'h0001), ent(2'b00, 16'h0002), ent(2'b00, 16'h0003), ent(2'b00, 16'h0004), 0);
        wait_done(400, ok);
        checks++;
        if (!ok || txn_cnt !== 4 || txn_log[3] !== 24'h720004)
            $display("FAIL last_entry: got done=%b n=%0d %h expected 1 4 720004", ok, txn_cnt, txn_log[3]);
        else passes++;
        checks++;
        if (o_index !== 2'd3 || o_busy !== 1'b0) $display("FAIL last_index: got idx=%0d busy=%b expected 3,0", o_index, o_busy);
        else passes++;
        start_run(ent(2'b00, 16'h0A0B), ent(2'b11, 16'hFFFF), ent(2'b00, 16'h0C0D), ent(2'b10, 16'h0), 0);
        wait_done(300, ok);
        checks++;
        if (!ok || txn_cnt !== 1 || o_index !== 2'd1)
            $display("FAIL reserved_op: got done=%b n=%0d idx=%0d expected 1 1 1", ok, txn_cnt, o_index);
        else passes++;
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        rst_n       = 1'b0;
        restart     = 1'b0;
        table_bus   = '0;
        nack_budget = 0;
        txn_cnt     = 0;
        test_reset();
        test_write_seq();
        test_delay();
        test_nack();
        test_restart();
        test_reset_mid_delay();
        test_table_end();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
